// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB with 2-bit counters and a 1-cycle registered lookup
// Optional feature macro: BTB_BYPASS_EN (same-index lookup sees the update applied in that cycle)
// Ports: i_clk/i_rst (sync, active-high) clock and reset; i_log_fd update log descriptor (0 = off)
//        i_stall/i_flush hold or clear the prediction; i_fetch_valid/i_fetch_pc lookup request
//        o_pred_valid/o_pred_taken/o_pred_pc registered prediction
//        i_upd_* resolved-branch update from the branch unit
package branch_target_buffer_pkg;
   typedef logic [31:0] program_counter_t;
endpackage

module branch_target_buffer
   import branch_target_buffer_pkg::*;
#(
   parameter int ENTRIES = 64
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [31:0]      i_log_fd,
   input  logic             i_stall,
   input  logic             i_flush,
   input  logic             i_fetch_valid,
   input  program_counter_t i_fetch_pc,
   output logic             o_pred_valid,
   output logic             o_pred_taken,
   output program_counter_t o_pred_pc,
   input  logic             i_upd_e,
   input  program_counter_t i_upd_pc,
   input  logic             i_upd_taken,
   input  program_counter_t i_upd_dest_pc,
   input  logic             i_upd_uncond,
   input  logic             i_upd_misalign
);
   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = 31 - IDX_W;
   logic [ENTRIES-1:0] valid;
   logic [TAG_W-1:0]   tag_mem [ENTRIES];
   logic [30:0]        tgt_mem [ENTRIES];
   logic [1:0]         ctr_mem [ENTRIES];
   logic [IDX_W-1:0]   u_idx, f_idx;
   logic [TAG_W-1:0]   u_tag, f_tag, e_tag;
   logic [30:0]        u_tgt, e_tgt;
   logic [1:0]         u_ctr, e_ctr;
   logic               u_apply, u_hit, u_write, byp, e_valid, f_taken;
   logic               unused_ok;
   // bit 0 of every PC is always zero on a 16-bit aligned ISA
   assign unused_ok = ^{i_fetch_pc[0], i_upd_pc[0], i_upd_dest_pc[0]};
   assign u_idx = i_upd_pc[IDX_W:1];
   assign u_tag = i_upd_pc[31:IDX_W+1];
   assign f_idx = i_fetch_pc[IDX_W:1];
   assign f_tag = i_fetch_pc[31:IDX_W+1];
   always_comb begin
      u_apply = i_upd_e && !i_upd_misalign && !i_rst;
      u_hit   = valid[u_idx] && tag_mem[u_idx] == u_tag;
      // a not-taken miss never allocates, so it leaves the table untouched
      u_write = u_apply && (u_hit || i_upd_taken);
      u_tgt   = i_upd_taken ? i_upd_dest_pc[31:1] : tgt_mem[u_idx];
      u_ctr   = !u_hit ? (i_upd_uncond ? 2'd3 : 2'd2) :
                i_upd_taken ? (ctr_mem[u_idx] == 2'd3 ? 2'd3 : ctr_mem[u_idx] + 2'd1) :
                (ctr_mem[u_idx] == 2'd0 ? 2'd0 : ctr_mem[u_idx] - 2'd1);
   end
`ifdef BTB_BYPASS_EN
   assign byp = u_write && u_idx == f_idx;
`else
   assign byp = 1'b0;
`endif
   always_comb begin
      e_valid = byp || valid[f_idx];
      e_tag   = byp ? u_tag : tag_mem[f_idx];
      e_tgt   = byp ? u_tgt : tgt_mem[f_idx];
      e_ctr   = byp ? u_ctr : ctr_mem[f_idx];
      f_taken = e_valid && e_tag == f_tag && e_ctr[1];
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) valid <= '0;
      else if (u_write) valid[u_idx] <= 1'b1;
   end
   always_ff @(posedge i_clk) begin
      if (u_write) begin
         tag_mem[u_idx] <= u_tag;
         tgt_mem[u_idx] <= u_tgt;
         ctr_mem[u_idx] <= u_ctr;
      end
   end
   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         o_pred_valid <= 1'b0;
         o_pred_taken <= 1'b0;
         o_pred_pc    <= '0;
      end else if (!i_stall) begin
         o_pred_valid <= i_fetch_valid;
         o_pred_taken <= i_fetch_valid && f_taken;
         o_pred_pc    <= (i_fetch_valid && f_taken) ? {e_tgt, 1'b0} : '0;
      end
   end
`ifndef SYNTHESIS
   always_ff @(posedge i_clk) begin
      if (u_apply && i_log_fd != 0)
         $display("[BTB] pc=%h taken=%0d dest=%h ctr=%0d",
                  i_upd_pc, i_upd_taken, i_upd_dest_pc, u_write ? u_ctr : ctr_mem[u_idx]);
   end
`endif
endmodule

// File: tb/tb_branch_target_buffer.sv
// tb_branch_target_buffer: directed and randomized checks of branch_target_buffer against an entry-table model
module tb_branch_target_buffer;
   import branch_target_buffer_pkg::*;
   localparam int N = 64;
   logic clk = 1'b0;
   logic rst = 1'b0, stall, flush, fv, upd_e, ut, uu, um;
   program_counter_t fpc, upc, udest, ppc;
   logic [31:0] log_fd;
   logic pv, pt;
   int checks = 0, errors = 0;
   bit m_on = 0;
   bit m_v [N];
   logic [31:0] m_tag [N], m_tgt [N];
   int m_ctr [N];
   bit exp_v, exp_t;
   logic [31:0] exp_pc;

   branch_target_buffer #(.ENTRIES(N)) dut (
      .i_clk(clk), .i_rst(rst), .i_log_fd(log_fd), .i_stall(stall), .i_flush(flush),
      .i_fetch_valid(fv), .i_fetch_pc(fpc),
      .o_pred_valid(pv), .o_pred_taken(pt), .o_pred_pc(ppc),
      .i_upd_e(upd_e), .i_upd_pc(upc), .i_upd_taken(ut), .i_upd_dest_pc(udest),
      .i_upd_uncond(uu), .i_upd_misalign(um)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
      end
   endtask

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc >> 1) % N);
   endfunction

   function automatic void m_look(input logic [31:0] pc, output bit t, output logic [31:0] tgt);
      int i = idx_of(pc);
      t   = m_v[i] && m_tag[i] == (pc >> 7) && m_ctr[i] >= 2;
      tgt = m_tgt[i];
   endfunction

   function automatic void m_upd();
      int i = idx_of(upc);
      bit hit = m_v[i] && m_tag[i] == (upc >> 7);
      if (!upd_e || um) return;
      if (hit) begin
         m_ctr[i] = ut ? (m_ctr[i] < 3 ? m_ctr[i] + 1 : 3) : (m_ctr[i] > 0 ? m_ctr[i] - 1 : 0);
         if (ut) m_tgt[i] = udest & ~32'd1;
      end else if (ut) begin
         m_v[i] = 1;
         m_tag[i] = upc >> 7;
         m_tgt[i] = udest & ~32'd1;
         m_ctr[i] = uu ? 3 : 2;
      end
   endfunction

   always @(posedge clk) begin : model
      bit lt;
      logic [31:0] lp;
      if (rst) begin
         for (int i = 0; i < N; i++) m_v[i] = 0;
         exp_v = 0; exp_t = 0; exp_pc = 0; m_on = 1;
      end else begin
`ifdef BTB_BYPASS_EN
         m_upd();
         m_look(fpc, lt, lp);
`else
         m_look(fpc, lt, lp);
         m_upd();
`endif
         if (flush) begin
            exp_v = 0; exp_t = 0; exp_pc = 0;
         end else if (!stall) begin
            exp_v = fv; exp_t = fv && lt; exp_pc = (fv && lt) ? lp : 0;
         end
      end
   end

   always @(negedge clk) begin
      if (m_on) begin
         chk("cyc.valid", 32'(pv), 32'(exp_v));
         if (exp_v) begin
            chk("cyc.taken", 32'(pt), 32'(exp_t));
            chk("cyc.pc", ppc, exp_pc);
         end
      end
   end

   task automatic idle();
      rst = 0; stall = 0; flush = 0; fv = 0; fpc = 0;
      upd_e = 0; upc = 0; ut = 0; udest = 0; uu = 0; um = 0;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic lit(input string n, input bit v, input bit t, input logic [31:0] p);
      chk({n, ".valid"}, 32'(pv), 32'(v));
      chk({n, ".taken"}, 32'(pt), 32'(t));
      chk({n, ".pc"}, ppc, p);
      chk({n, ".model"}, {exp_pc[31:2], exp_t, exp_v}, {p[31:2], t, v});
   endtask

   task automatic look(input logic [31:0] pc);
      idle(); fv = 1; fpc = pc; step();
   endtask

   task automatic upd(input logic [31:0] pc, input bit t, input logic [31:0] d, input bit u);
      idle(); upd_e = 1; upc = pc; ut = t; udest = d; uu = u; step();
   endtask

   initial begin
      log_fd = 0;
      idle();
      rst = 1; step();
      lit("reset", 0, 0, 0);
      look(32'h1000); lit("cold", 1, 0, 0);
      upd(32'h1000, 1, 32'h2000, 0);
      look(32'h1000); lit("alloc", 1, 1, 32'h2000);
      upd(32'h1000, 0, 0, 0);
      upd(32'h1000, 0, 0, 0);
      look(32'h1000); lit("dec", 1, 0, 0);
      repeat (5) upd(32'h1000, 1, 32'h2000, 0);
      upd(32'h1000, 0, 0, 0);
      look(32'h1000); lit("sat", 1, 1, 32'h2000);
      upd(32'h1080, 1, 32'h3000, 0);
      look(32'h1000); lit("alias_old", 1, 0, 0);
      look(32'h1080); lit("alias_new", 1, 1, 32'h3000);
      idle(); fv = 1; fpc = 32'h1004; upd_e = 1; upc = 32'h1004; ut = 1; udest = 32'h4000; step();
`ifdef BTB_BYPASS_EN
      lit("same_idx", 1, 1, 32'h4000);
`else
      lit("same_idx", 1, 0, 0);
`endif
      idle(); upd_e = 1; upc = 32'h1008; ut = 1; udest = 32'h5000; um = 1; step();
      look(32'h1008); lit("misalign", 1, 0, 0);
      look(32'h1080);
      for (int i = 0; i < 3; i++) begin
         idle(); stall = 1; fv = 1; fpc = 32'h1000; step();
         lit("stall", 1, 1, 32'h3000);
      end
      idle(); stall = 1; flush = 1; fv = 1; fpc = 32'h1080; step();
      lit("flush", 0, 0, 0);
      upd(32'h1000, 1, 32'h2000, 0);
      look(32'h1000); lit("reinstall", 1, 1, 32'h2000);
      idle(); rst = 1; fv = 1; fpc = 32'h1000; step();
      lit("rst_pulse", 0, 0, 0);
      look(32'h1000); lit("after_rst", 1, 0, 0);
      for (int i = 0; i < 3000; i++) begin
         rst   = $urandom_range(0, 299) == 0;
         stall = $urandom_range(0, 4) == 0;
         flush = $urandom_range(0, 19) == 0;
         fv    = $urandom_range(0, 3) != 0;
         fpc   = 32'h1000 + ($urandom_range(0, 3) << 7) + ($urandom_range(0, 7) << 1);
         upd_e = 1'($urandom_range(0, 1));
         upc   = 32'h1000 + ($urandom_range(0, 3) << 7) + ($urandom_range(0, 7) << 1);
         ut    = 1'($urandom_range(0, 1));
         uu    = $urandom_range(0, 3) == 0;
         um    = $urandom_range(0, 7) == 0;
         udest = $urandom & ~32'd1;
         step();
      end
      idle(); step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
